// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: clause-22 MDIO PHY register responder, MDC oversampled on clk.
// Optional MDIO_PREAMBLE_SUPPRESS_EN: after any completed frame, a new ST is accepted without preamble.
module mdio_phy_responder #(
   parameter logic [4:0]  PHY_ADDR = 5'd1,
   parameter logic [15:0] PHY_ID1  = 16'h0022,
   parameter logic [15:0] PHY_ID2  = 16'h1620
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mdc_i,
   input  logic mdio_i,
   output logic mdio_o,
   output logic mdio_oe_o,
   input  logic link_up_i,
   output logic mdint_o,
   output logic phy_reset_o
);
   localparam logic [2:0] PRE = 3'd0, ST = 3'd1, OP = 3'd2, ADDR = 3'd3,
                          TA = 3'd4, WDATA = 3'd5, RDATA = 3'd6;
   logic [1:0] mdc_s, mdio_s;
   logic mdc_q, link_q, rd, sel, drv, pre_ok;
   logic [2:0] state;
   logic [5:0] cnt;
   logic [15:0] sh, rval;
   logic [4:0] ra;
   logic [14:0] r0;
   logic [15:0] r47 [4];
   wire re = mdc_s[1] & ~mdc_q;
   wire b = mdio_s[1];
   wire [15:0] wd = {sh[14:0], b};
   wire done_rd = re & (state == RDATA) & (cnt == 6'd16);
   wire done_wr = re & (state == WDATA) & (cnt == 6'd15);
   assign mdio_o = drv | ~mdio_oe_o;
   always_comb
      rval = ra == 5'd0 ? {1'b0, r0} :
             ra == 5'd1 ? (16'h7809 | {13'b0, link_up_i, 2'b0}) :
             ra == 5'd2 ? PHY_ID1 :
             ra == 5'd3 ? PHY_ID2 :
             ra[4:2] == 3'b001 ? r47[ra[1:0]] : 16'h0000;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   logic sup;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sup <= 1'b0;
      else if (done_rd | done_wr) sup <= 1'b1;
   assign pre_ok = (cnt == 6'd32) | sup;
`else
   assign pre_ok = cnt == 6'd32;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mdc_s  <= 2'b00;
         mdio_s <= 2'b00;
         mdc_q  <= 1'b0;
      end else begin
         mdc_s  <= {mdc_s[0], mdc_i};
         mdio_s <= {mdio_s[0], mdio_i};
         mdc_q  <= mdc_s[1];
      end
   // frame decoder; every transition happens on a sampled MDC rising edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= PRE;
         cnt       <= 6'd0;
         sh        <= 16'h0000;
         rd        <= 1'b0;
         sel       <= 1'b0;
         ra        <= 5'd0;
         drv       <= 1'b1;
         mdio_oe_o <= 1'b0;
      end else if (re) begin
         case (state)
            PRE: if (b) cnt <= (cnt == 6'd32) ? cnt : cnt + 6'd1;
                 else begin
                    cnt <= 6'd0;
                    if (pre_ok) state <= ST;
                 end
            ST: begin
               state <= b ? OP : PRE;
               cnt   <= 6'd0;
            end
            OP: begin
               sh  <= wd;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd1) begin
                  cnt   <= 6'd0;
                  rd    <= wd[1];
                  state <= (wd[1] ^ wd[0]) ? ADDR : PRE;
               end
            end
            ADDR: begin
               sh  <= wd;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd9) begin
                  cnt   <= 6'd0;
                  sel   <= wd[9:5] == PHY_ADDR;
                  ra    <= wd[4:0];
                  state <= TA;
               end
            end
            TA: if (rd) begin
                   sh        <= rval;
                   mdio_oe_o <= sel;
                   drv       <= 1'b0;
                   cnt       <= 6'd0;
                   state     <= RDATA;
                end else if (cnt == 6'd1) begin
                   cnt   <= 6'd0;
                   state <= WDATA;
                end else cnt <= cnt + 6'd1;
            WDATA: begin
               sh  <= wd;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd15) begin
                  cnt   <= 6'd0;
                  state <= PRE;
               end
            end
            RDATA: if (cnt == 6'd16) begin
                      mdio_oe_o <= 1'b0;
                      drv       <= 1'b1;
                      cnt       <= 6'd0;
                      state     <= PRE;
                   end else begin
                      drv <= sh[15];
                      sh  <= {sh[14:0], 1'b0};
                      cnt <= cnt + 6'd1;
                   end
            default: begin
               state <= PRE;
               cnt   <= 6'd0;
            end
         endcase
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r0          <= 15'h1140;
         for (int i = 0; i < 4; i++) r47[i] <= 16'h0000;
         phy_reset_o <= 1'b0;
         mdint_o     <= 1'b0;
         link_q      <= 1'b0;
      end else begin
         link_q      <= link_up_i;
         phy_reset_o <= done_wr & sel & (ra == 5'd0) & wd[15];
         if (done_wr & sel & (ra == 5'd0)) r0 <= wd[14:0];
         if (done_wr & sel & (ra[4:2] == 3'b001)) r47[ra[1:0]] <= wd;
         // a link change in the same clk as the clearing read keeps the interrupt set
         mdint_o <= (link_up_i != link_q) | (mdint_o & ~(done_rd & sel & (ra == 5'd1)));
      end
endmodule

// File: doc/mdio_phy_responder.md
MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 Parameter PHY_ADDR, default 5'd1: PHY address this responder answers to.
REQ-002 Parameter PHY_ID1, default 16'h0022: value returned for register 2.
REQ-003 Parameter PHY_ID2, default 16'h1620: value returned for register 3.
REQ-004 clk  in  1  system clock; the only clock; MDC is oversampled on it.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 mdc_i  in  1  management clock from the MAC (its mdc_clk).
REQ-007 mdio_i  in  1  management data from the MAC (its mdo).
REQ-008 mdio_o  out  1  management data to the MAC (its mdi).
REQ-009 mdio_oe_o  out  1  drive enable for mdio_o; 1 = responder owns the line.
REQ-010 link_up_i  in  1  link status, synchronous to clk.
REQ-011 mdint_o  out  1  management interrupt (MAC mdint), active high.
REQ-012 phy_reset_o  out  1  one-clk pulse on software reset via register 0 bit 15.

Function
REQ-013 mdc_i and mdio_i shall pass through 2-flop synchronisers; an MDC rising edge (RE) is detected when synced MDC is 1 and its previous value is 0.
REQ-014 MDC high and low phases shall each be at least 4 clk; shorter phases are unsupported.
REQ-015 Every frame bit shall be sampled on an RE.
REQ-016 States: PRE, ST, OP, ADDR, TA, WDATA, RDATA.
REQ-017 PRE: count consecutive 1s, saturating at 32; a 0 with count < 32 resets count to 0; a 0 with count = 32 goes to ST.
REQ-018 ST: a 1 goes to OP; a 0 goes to PRE with count 0.
REQ-019 OP: 2 bits; 10 = read, 01 = write, then ADDR; 00 or 11 goes to PRE with count 0.
REQ-020 ADDR: 10 bits, PHYAD[4:0] then REGAD[4:0], MSB first; selected = (PHYAD == PHY_ADDR). RE E0 samples the last REGAD bit.
REQ-021 Read, selected: load the shift register with the register value at E1; in the clk after E1, assert mdio_oe_o with mdio_o = 0.
REQ-022 Read, selected: in the clk after E2..E17, drive D15..D0 in turn; in the clk after E18, deassert mdio_oe_o and go to PRE with count 0.
REQ-023 Write: ignore E1 and E2 (TA); shift data MSB first on E3..E18; if selected, update the register in the clk after E18; go to PRE with count 0.
REQ-024 Unselected frames shall run the same bit count, never assert mdio_oe_o, and never write.
REQ-025 Register 0: read/write, reset value 16'h1140; bit 15 shall not be stored and always reads 0; writing bit 15 = 1 pulses phy_reset_o for 1 clk.
REQ-026 Register 1: read-only, value 16'h7809 with bit 2 = link_up_i at load time.
REQ-027 Registers 2 and 3: read-only, PHY_ID1 and PHY_ID2.
REQ-028 Registers 4..7: read/write, reset value 16'h0000.
REQ-029 Registers 8..31: read 16'h0000; writes ignored.
REQ-030 mdint_o shall set in the clk after link_up_i changes and clear in the clk after E18 of a selected read of register 1.
REQ-031 If mdint_o set and clear occur in the same clk, set wins.
REQ-032 When mdio_oe_o = 0, mdio_o shall be 1.
REQ-033 There is no MDC timeout; a stalled MDC holds the current state.

Reset
REQ-034 rst_n low shall immediately force: state PRE, count 0, mdio_oe_o 0, mdio_o 1, mdint_o 0, phy_reset_o 0, register 0 = 16'h1140, registers 4..7 = 0, synchronisers = 0.
REQ-035 Reset mid-frame shall abort the frame with no register write; 32 ones are then needed before a new ST.

Configuration
REQ-036 MDIO_PREAMBLE_SUPPRESS_EN defined: after a completed frame (any exit from REQ-022 or REQ-023), PRE shall accept a 0 as ST with any count, until the next reset.
REQ-037 MDIO_PREAMBLE_SUPPRESS_EN undefined: every frame requires 32 preamble ones, per REQ-017.

Verification
REQ-038 Reset, 32 ones, read of register 2 at PHYAD 1, MDC = 8 clk -> mdio_oe_o rises after E1; line carries 0 then 16'h0022; mdio_oe_o falls after E18.
REQ-039 Write 16'hA5A5 to register 5, then read register 5 -> 16'hA5A5; write to register 9, then read -> 16'h0000.
REQ-040 Write 16'h9140 to register 0 -> one 1-clk phy_reset_o pulse; read register 0 -> 16'h1140.
REQ-041 Read register 2 at PHYAD 3 -> mdio_oe_o stays 0; a following correct frame still decodes.
REQ-042 Toggle link_up_i 0->1 -> mdint_o = 1; read register 1 -> 16'h780D, mdint_o = 0 after E18; link toggle in the E18 clk -> mdint_o stays 1.
REQ-043 rst_n low during read data bit D8 -> mdio_oe_o = 0 at once; back-to-back frame without preamble -> ignored when MDIO_PREAMBLE_SUPPRESS_EN is undefined, decoded when it is defined.
